// File: rtl/ex_result_buffer_pkg.sv
// Shared EX/MEM result definitions: select encodings, default widths and the
// result-entry bundle that downstream MEM/WB stages also carry.
package ex_result_buffer_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] RES_SEL_ALU = 2'b00;
  localparam logic [1:0] RES_SEL_SET = 2'b01;
  localparam logic [1:0] RES_SEL_PC  = 2'b10;
  localparam logic [1:0] RES_SEL_ILL = 2'b11;

  typedef struct packed {
    logic [XLEN_DEF-1:0]   data;
    logic [REG_AW_DEF-1:0] rd;
    logic                  wr;
  } res_entry_t;

endpackage

// File: rtl/result_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The head (main) entry drives the
// outputs; in_ready depends only on registered state.
module result_skid_buf
  import ex_result_buffer_pkg::*;
#(
  parameter type entry_t = res_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  logic [1:0] state;
  entry_t     main_q;
  entry_t     skid_q;
  logic       in_fire;
  logic       out_fire;

  assign in_ready  = (state == ST_EMPTY) || (state == ST_ONE);
  assign out_valid = (state == ST_ONE) || (state == ST_FULL);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Flush outranks any simultaneous accept or drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            state  <= ST_FULL;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ex_result_buffer.sv
// EX->MEM stage: selects the execute result, masks x0/illegal writes, flags
// illegal selects and buffers the tagged result in a 2-entry skid buffer.
module ex_result_buffer
  import ex_result_buffer_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [XLEN-1:0]   ALU_Res,
  input  logic [XLEN-1:0]   Set_Res,
  input  logic [XLEN-1:0]   PC_Plus4,
  input  logic [1:0]        Res_Sel,
  input  logic [REG_AW-1:0] Rd_Addr,
  input  logic              Reg_Wr,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [XLEN-1:0]   Result,
  output logic [REG_AW-1:0] Rd_Addr_o,
  output logic              Reg_Wr_o,
  output logic              Sel_Err
);

  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [REG_AW-1:0] rd;
    logic              wr;
  } entry_t;

  entry_t in_entry;
  entry_t out_entry;
  logic   sel_ill;
  logic   in_fire;

  assign sel_ill = (Res_Sel == RES_SEL_ILL);
  assign in_fire = In_Valid & In_Ready & ~Flush;

  // Illegal selects capture zero data and never write; x0 is never written.
  always_comb begin
    in_entry    = '0;
    in_entry.rd = Rd_Addr;
    in_entry.wr = Reg_Wr & (Rd_Addr != '0) & ~sel_ill;
    case (Res_Sel)
      RES_SEL_ALU: in_entry.data = ALU_Res;
      RES_SEL_SET: in_entry.data = Set_Res;
      RES_SEL_PC:  in_entry.data = PC_Plus4;
      default:     in_entry.data = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) Sel_Err <= 1'b0;
    else        Sel_Err <= in_fire & sel_ill;
  end

  result_skid_buf #(
    .entry_t(entry_t)
  ) u_skid (
    .clk      (CLK),
    .rst_n    (rst_n),
    .flush    (Flush),
    .in_valid (In_Valid),
    .in_ready (In_Ready),
    .in_data  (in_entry),
    .out_valid(Out_Valid),
    .out_ready(Out_Ready),
    .out_data (out_entry)
  );

  assign Result    = out_entry.data;
  assign Rd_Addr_o = out_entry.rd;
  assign Reg_Wr_o  = out_entry.wr;

endmodule

// File: tb/tb_ex_result_buffer.sv
// Randomized scoreboard bench for ex_result_buffer: driver queues expected
// results on acceptance, monitor pops and compares on each drained beat.
module tb_ex_result_buffer;

  logic        CLK;
  logic        rst_n;
  logic        Flush;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] ALU_Res;
  logic [31:0] Set_Res;
  logic [31:0] PC_Plus4;
  logic [1:0]  Res_Sel;
  logic [4:0]  Rd_Addr;
  logic        Reg_Wr;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Result;
  logic [4:0]  Rd_Addr_o;
  logic        Reg_Wr_o;
  logic        Sel_Err;

  ex_result_buffer #(.XLEN(32), .REG_AW(5)) dut (
    .CLK(CLK), .rst_n(rst_n), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .ALU_Res(ALU_Res), .Set_Res(Set_Res), .PC_Plus4(PC_Plus4), .Res_Sel(Res_Sel),
    .Rd_Addr(Rd_Addr), .Reg_Wr(Reg_Wr), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Result(Result), .Rd_Addr_o(Rd_Addr_o), .Reg_Wr_o(Reg_Wr_o), .Sel_Err(Sel_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   sel_err_exp = 1'b0;

  function automatic exp_t ref_model(input logic [1:0] sel, input logic [31:0] alu,
                                     input logic [31:0] set, input logic [31:0] pc,
                                     input logic [4:0] rd, input logic wr);
    exp_t e;
    e.rd = rd;
    e.wr = wr && (rd != 0) && (sel != 2'd3);
    case (sel)
      2'd0:    e.data = alu;
      2'd1:    e.data = set;
      2'd2:    e.data = pc;
      default: e.data = 32'h0;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] set, input logic [31:0] pc, input logic [4:0] rd,
                       input logic wr, input logic ordy, input logic fl, output bit fire);
    logic rdy;
    In_Valid = v; Res_Sel = sel; ALU_Res = alu; Set_Res = set; PC_Plus4 = pc;
    Rd_Addr = rd; Reg_Wr = wr; Out_Ready = ordy; Flush = fl;
    @(negedge CLK);
    rdy = In_Ready;
    @(posedge CLK);
    fire = v && rdy && !fl;
    sel_err_exp = fire && (sel == 2'd3);
    if (fire) sb.push_back(ref_model(sel, alu, set, pc, rd, wr));
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    bit f;
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, ordy, 1'b0, f);
  endtask

  task automatic send(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] set,
                      input logic [31:0] pc, input logic [4:0] rd, input logic wr,
                      input logic ordy);
    bit f;
    f = 1'b0;
    for (int i = 0; i < 20 && !f; i++) drive(1'b1, sel, alu, set, pc, rd, wr, ordy, 1'b0, f);
    check("accept_timeout", f, 1);
  endtask

  task automatic rand_beat(input logic v, input logic ordy, input logic fl, output bit fire);
    drive(v, 2'($urandom_range(0, 3)), $urandom, {31'h0, 1'($urandom)}, $urandom,
          5'($urandom_range(0, 31)), 1'($urandom), ordy, fl, fire);
  endtask

  always @(negedge CLK) begin
    if (mon_en && rst_n) begin
      check("in_ready", In_Ready, sb.size() < 2);
      check("out_valid", Out_Valid, sb.size() != 0);
      check("sel_err", Sel_Err, sel_err_exp);
      if (Out_Valid && sb.size() != 0) begin
        check("result", Result, sb[0].data);
        check("rd_addr", Rd_Addr_o, sb[0].rd);
        check("reg_wr", Reg_Wr_o, sb[0].wr);
        if (Out_Ready && !Flush) void'(sb.pop_front());
      end
      if (Flush) sb.delete();
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, Out_Valid, 0);
    check({tag, "_in_ready"}, In_Ready, 1);
    check({tag, "_result"}, Result, 0);
    check({tag, "_rd_addr"}, Rd_Addr_o, 0);
    check({tag, "_reg_wr"}, Reg_Wr_o, 0);
    check({tag, "_sel_err"}, Sel_Err, 0);
  endtask

  initial begin
    bit f;
    rst_n = 1'b0; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
    ALU_Res = '0; Set_Res = '0; PC_Plus4 = '0; Res_Sel = '0; Rd_Addr = '0; Reg_Wr = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Select paths
    send(2'd1, 32'hFFFF_0000, 32'h1, 32'h0, 5'd5, 1'b1, 1'b1);
    send(2'd2, 32'h0, 32'h0, 32'h104, 5'd1, 1'b1, 1'b1);
    send(2'd0, 32'h1234_5678, 32'h0, 32'h0, 5'd31, 1'b1, 1'b1);
    idle(1'b1, 2);

    // x0 masking and illegal select
    send(2'd0, 32'hDEAD, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
    send(2'd3, 32'h55, 32'h1, 32'h8, 5'd7, 1'b1, 1'b1);
    idle(1'b1, 3);

    // Backpressure: A, B fill the buffer; C is held off until draining starts
    send(2'd0, 32'hA, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0);
    send(2'd0, 32'hB, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd0, 32'hC, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, f);
      check("held_off", f, 0);
    end
    send(2'd0, 32'hC, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1);
    idle(1'b1, 3);

    // Streaming at full rate
    for (int i = 0; i < 50; i++) begin
      rand_beat(1'b1, 1'b1, 1'b0, f);
      check("stream_accept", f, 1);
    end
    idle(1'b1, 3);

    // Flush in FULL with a beat offered
    send(2'd0, 32'h11, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0);
    send(2'd0, 32'h22, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0);
    drive(1'b1, 2'd0, 32'hD0D0, 32'h0, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, f);
    check("flush_full_discard", f, 0);
    idle(1'b1, 3);

    // Flush in ONE with an illegal-select beat offered: discarded, no Sel_Err
    send(2'd0, 32'h33, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0);
    drive(1'b1, 2'd3, 32'hBAD, 32'h0, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1, f);
    check("flush_one_discard", f, 0);
    idle(1'b1, 3);

    // Random traffic with backpressure and occasional flush
    for (int i = 0; i < 300; i++)
      rand_beat($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 19) == 0, f);
    idle(1'b1, 3);

    // Asynchronous reset while FULL
    send(2'd0, 32'h44, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0);
    send(2'd1, 32'h0, 32'h1, 32'h0, 5'd14, 1'b1, 1'b0);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    sb.delete();
    sel_err_exp = 1'b0;
    In_Valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    send(2'd0, 32'h77, 32'h0, 32'h0, 5'd15, 1'b1, 1'b1);
    idle(1'b1, 5);
    check("drain_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
